hazard_sequencer: RTL

Pipeline sequencer for the 5-stage RISC-V core. It detects load-use hazards and generates the bubble that drives the control unit's no-op input. It flushes IF/ID on taken branches and freezes the whole pipeline while the data memory is not ready, with a watchdog that halts the core on a memory timeout. Saturating stall and flush counters are exposed for performance monitoring.

---
 rtl/cpu_pkg.sv | 24 ++
 rtl/hazard_sequencer_sat_counter.sv | 40 ++++
 rtl/hazard_sequencer.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg
//   Definitions shared by the pipeline-control blocks of the 5-stage core.
//   - state_t / ST_*  : encoding of the hazard sequencer FSM
//   - REG_X0          : architectural zero register (never a real dependency)
//   - load_use()      : load-use hazard between the EX load and the ID sources
package cpu_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_RUN      = 2'd0;
   localparam state_t ST_MEM_WAIT = 2'd1;
   localparam state_t ST_HALT     = 2'd2;

   localparam logic [4:0] REG_X0 = 5'd0;

   // A load into x0 never produces a value, so it cannot create a hazard.
   function automatic logic load_use(input logic       mem_read,
                                     input logic [4:0] rd,
                                     input logic [4:0] rs1,
                                     input logic [4:0] rs2);
      return mem_read && (rd != REG_X0) && ((rd == rs1) || (rd == rs2));
   endfunction

endpackage

// File: rtl/hazard_sequencer_sat_counter.sv
// sat_counter
//   Saturating up-counter used for the performance monitors.
//   Ports:
//     clk_i  - clock, counts on the rising edge
//     rst_i  - asynchronous active-low reset, clears the count
//     inc_i  - count this cycle
//     cnt_o  - current count, holds at all-ones once saturated
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         inc_i,
   output logic [W-1:0] cnt_o
);

   localparam logic [W-1:0] CNT_ONE = {{(W-1){1'b0}}, 1'b1};
   localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (inc_i && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + CNT_ONE;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_sequencer.sv
// hazard_sequencer
//   Pipeline sequencer for the 5-stage core: load-use bubbles, IF/ID flush on
//   taken branches, whole-pipeline freeze while data memory is busy, and a
//   watchdog that halts the core when memory never answers.
//   Parameters:
//     TIMEOUT - consecutive frozen memory cycles before HALT (>= 2)
//     CNT_W   - width of the performance counters
//   Ports:
//     clk_i, rst_i               - clock, asynchronous active-low reset
//     ID_Rs1_i, ID_Rs2_i         - sources of the instruction in ID
//     EX_Rd_i, EX_MemRead_i      - destination / load flag of the instruction in EX
//     Branch_Taken_i             - branch in ID resolved taken
//     MEM_Access_i, MemReady_i   - memory access in MEM / memory completes it
//     PCWrite_o, IFIDWrite_o     - front-end enables
//     NoOp_o                     - bubble into ID/EX
//     Flush_o                    - clear IF/ID
//     PipeStall_o                - freeze ID/EX, EX/MEM, MEM/WB
//     Halted_o                   - sticky memory timeout
//     StallCycles_o              - saturating count of PCWrite_o=0 cycles (not in HALT)
//     FlushCount_o               - saturating count of Flush_o=1 cycles
//     State_o                    - current FSM state (debug)
//
//   Handshake: a memory access is complete in the cycle where MEM_Access_i and
//   MemReady_i are both high; MemReady_i alone ends a wait once one has started.
module hazard_sequencer
   import cpu_pkg::*;
#(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [4:0]       ID_Rs1_i,
   input  logic [4:0]       ID_Rs2_i,
   input  logic [4:0]       EX_Rd_i,
   input  logic             EX_MemRead_i,
   input  logic             Branch_Taken_i,
   input  logic             MEM_Access_i,
   input  logic             MemReady_i,
   output logic             PCWrite_o,
   output logic             IFIDWrite_o,
   output logic             NoOp_o,
   output logic             Flush_o,
   output logic             PipeStall_o,
   output logic             Halted_o,
   output logic [CNT_W-1:0] StallCycles_o,
   output logic [CNT_W-1:0] FlushCount_o,
   output logic [1:0]       State_o
);

   localparam int WAIT_W = $clog2(TIMEOUT);
   localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

   state_t            state_q, state_d;
   logic [WAIT_W-1:0] wait_q,  wait_d;

   logic lu;
   logic mw;

   logic pc_write;
   logic ifid_write;
   logic noop;
   logic flush;
   logic pipe_stall;

   assign lu = load_use(EX_MemRead_i, EX_Rd_i, ID_Rs1_i, ID_Rs2_i);
   assign mw = MEM_Access_i & ~MemReady_i;

   // State register
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= ST_RUN;
         wait_q  <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
      end
   end

   // Next-state logic. wait_q counts frozen cycles, the RUN miss cycle being 1.
   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      case (state_q)
         ST_RUN: begin
            if (mw) begin
               state_d = ST_MEM_WAIT;
               wait_d  = WAIT_ONE;
            end
         end
         ST_MEM_WAIT: begin
            if (MemReady_i) begin
               state_d = ST_RUN;
               wait_d  = '0;
            end else if (wait_q == WAIT_LAST) begin
               state_d = ST_HALT;
            end else begin
               wait_d = wait_q + WAIT_ONE;
            end
         end
         ST_HALT: begin
            state_d = ST_HALT;
         end
         default: begin
            state_d = ST_RUN;
            wait_d  = '0;
         end
      endcase
   end

   // Output logic (Mealy). While reset is held the pipeline is frozen so that
   // nothing advances until the sequencer is running again.
   always_comb begin
      pc_write   = 1'b1;
      ifid_write = 1'b1;
      noop       = 1'b0;
      flush      = 1'b0;
      pipe_stall = 1'b0;
      if (!rst_i) begin
         pc_write   = 1'b0;
         ifid_write = 1'b0;
         pipe_stall = 1'b1;
      end else begin
         case (state_q)
            ST_RUN, ST_MEM_WAIT: begin
               if ((state_q == ST_RUN) ? mw : ~MemReady_i) begin
                  pc_write   = 1'b0;
                  ifid_write = 1'b0;
                  pipe_stall = 1'b1;
               end else if (lu) begin
                  // Bubble wins over a taken branch: the branch stays in ID
                  // and resolves again next cycle, so no flush now.
                  pc_write   = 1'b0;
                  ifid_write = 1'b0;
                  noop       = 1'b1;
               end else if (Branch_Taken_i) begin
                  flush = 1'b1;
               end
            end
            default: begin
               pc_write   = 1'b0;
               ifid_write = 1'b0;
               pipe_stall = 1'b1;
            end
         endcase
      end
   end

   assign PCWrite_o   = pc_write;
   assign IFIDWrite_o = ifid_write;
   assign NoOp_o      = noop;
   assign Flush_o     = flush;
   assign PipeStall_o = pipe_stall;
   assign Halted_o    = (state_q == ST_HALT);
   assign State_o     = state_q;

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .inc_i (~pc_write & (state_q != ST_HALT)),
      .cnt_o (StallCycles_o)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .inc_i (flush),
      .cnt_o (FlushCount_o)
   );

endmodule
